// File: rtl/veririsc_pkg.sv
// veririsc_pkg: opcode and phase encodings shared across the VeriRISC blocks
package veririsc_pkg;
  localparam int PHASE_W = 3;
  typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_e;
  typedef enum logic [PHASE_W-1:0] {INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE} phase_e;
  function automatic logic is_aluop(input logic [2:0] op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction
endpackage

// File: rtl/controller_phase_counter.sv
// phase_counter: wrapping instruction-phase counter with hold enable
module phase_counter
  import veririsc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [PHASE_W-1:0] count
);
  // advance one phase per enabled cycle, wrapping naturally at the top
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/controller.sv
// controller: VeriRISC instruction sequencer; memory-wait stall enabled by VERIRISC_STALL_EN
module controller
  import veririsc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef VERIRISC_STALL_EN
  input  logic       stall,
`endif
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);
  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be positive");
  end
  logic r_halted;
  logic w_stall;
  logic w_halt_now;
  logic w_aluop;
`ifdef VERIRISC_STALL_EN
  assign w_stall = stall & ~r_halted;
`else
  assign w_stall = 1'b0;
`endif
  assign w_halt_now = (phase == OP_ADDR) && (opcode == HLT);
  assign w_aluop    = is_aluop(opcode);
  // phase freezes once halted, while stalled, and on the edge that enters halt
  phase_counter u_phase (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (~r_halted & ~w_stall & ~w_halt_now),
    .count(phase)
  );
  // halted is sticky until reset; a stalled HLT waits for the stall to clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_halted <= 1'b0;
    else r_halted <= r_halted | (w_halt_now & ~w_stall);
  // per-phase strobe decode, then stall masks the edge-sensitive strobes
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = r_halted;
    if (!r_halted)
      case (phase)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: {sel, rd} = 2'b11;
        INST_LOAD,
        IDLE:       {sel, rd, ld_ir} = 3'b111;
        OP_ADDR:    {inc_pc, halt} = {1'b1, opcode == HLT};
        OP_FETCH:   rd = w_aluop;
        ALU_OP:     {rd, inc_pc, ld_pc, data_e} = {w_aluop, opcode == SKZ && zero, opcode == JMP, opcode == STO};
        STORE:      {rd, ld_ac, ld_pc, wr, data_e} = {w_aluop, w_aluop, opcode == JMP, opcode == STO, opcode == STO};
        default:    ;
      endcase
    if (w_stall) {ld_ir, inc_pc, ld_pc, ld_ac, wr} = 5'b0;
  end
endmodule

// File: doc/controller.md
# controller

Instruction-sequencing state machine for the VeriRISC CPU. Steps through the fixed 8-phase instruction cycle, decodes the 3-bit opcode held in the instruction register, and drives every datapath control strobe. It consumes the ALU's `a_is_zero` flag for `SKZ`. It sits directly upstream of the ALU/accumulator, PC, IR and memory interface.

## Interface
- `WIDTH`, default 8: datapath width. Not used internally; present for consistency with the other VeriRISC blocks.
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `opcode`, input, 3: current IR opcode.
- `zero`, input, 1: ALU `a_is_zero`, meaning accumulator == 0.
- `stall`, input, 1: memory wait. Present only with `VERIRISC_STALL_EN`.
- `sel`, output, 1: address mux select; 1 = PC, 0 = IR operand.
- `rd`, output, 1: memory read enable.
- `ld_ir`, output, 1: IR load strobe.
- `inc_pc`, output, 1: PC increment strobe.
- `ld_pc`, output, 1: PC load strobe (jump).
- `ld_ac`, output, 1: accumulator load strobe.
- `wr`, output, 1: memory write strobe.
- `data_e`, output, 1: accumulator drives the data bus.
- `halt`, output, 1: CPU halted.
- `phase`, output, 3: current phase, for debug.

## Operation
- Phase register, 3 bits. Advances 0→1→…→7→0 every cycle. One instruction takes 8 cycles.
- Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Opcodes: HLT 0, SKZ 1, ADD 2, AND 3, XOR 4, LDA 5, STO 6, JMP 7.
- ALUOP is true for ADD, AND, XOR and LDA.
- Decode per phase (signals not listed are 0):
  - Phase 0: `sel`.
  - Phase 1: `sel`, `rd`.
  - Phase 2: `sel`, `rd`, `ld_ir`.
  - Phase 3: `sel`, `rd`, `ld_ir`.
  - Phase 4: `inc_pc`; `halt` = (opcode == HLT).
  - Phase 5: `rd` = ALUOP.
  - Phase 6: `rd` = ALUOP; `inc_pc` = SKZ & `zero`; `ld_pc` = JMP; `data_e` = STO.
  - Phase 7: `rd` = ALUOP; `ld_ac` = ALUOP; `ld_pc` = JMP; `wr` = STO; `data_e` = STO.
- Halted flag:
  - Set on the rising edge that leaves phase 4 while opcode == HLT.
  - While set: phase frozen at 4, `halt` = 1, all other controls = 0.
  - `opcode` and `zero` are ignored while halted.
  - Cleared only by reset.
- `zero` and `opcode` are sampled combinationally in the phase where they are used. No internal copy is kept.

## Timing
- Reset (asynchronous, takes effect immediately): phase = 0, halted = 0. Outputs are then `sel` = 1, `phase` = 0, and every other output 0.
- Release of `rst_n`: the first rising edge afterwards moves to phase 1.
- Outputs are combinational from the phase register, the halted flag, `opcode`, `zero` and `stall`. There is no output register.
- HLT:
  - `halt` first rises combinationally in phase 4.
  - `inc_pc` pulses once in that cycle.
  - From the next edge, `halt` stays 1 and nothing else changes.
- Reset mid-instruction aborts that instruction immediately. No strobe survives reset.

## Configuration
- `VERIRISC_STALL_EN` defined:
  - `stall` port exists.
  - With `stall` = 1, phase and halted hold.
  - Strobes `ld_ir`, `inc_pc`, `ld_pc`, `ld_ac` and `wr` are forced to 0.
  - Levels `sel`, `rd`, `data_e` and `halt` remain as decoded.
  - `stall` has no effect while halted.
  - Stall in phase 4 with HLT delays setting the halted flag until the cycle in which `stall` = 0.
- Undefined: no `stall` port; phase advances unconditionally.

## Structure
- Shared package `veririsc_pkg` holds:
  - The opcode constants HLT..JMP, also used by `alu` and its bench.
  - The phase constants INST_ADDR..STORE.
- One natural sub-module, `phase_counter`: 3-bit wrapping counter with async active-low reset, an enable input (hold on stall or halted) and count output.
- Decode stays in `controller`.

## Test plan
- Reset: assert `rst_n` = 0 mid-phase 5.
  - Expect phase = 0, `sel` = 1 and all others 0 immediately, with no clock edge needed.
- ADD (opcode 2), 8 cycles:
  - `ld_ir` in phases 2–3.
  - `inc_pc` in phase 4.
  - `rd` in phases 5–7.
  - `ld_ac` only in phase 7.
  - Phase returns to 0 on cycle 9.
- SKZ (opcode 1):
  - With `zero` = 1: `inc_pc` in phases 4 and 6.
  - With `zero` = 0: `inc_pc` in phase 4 only.
- STO (6) and JMP (7):
  - STO: `data_e` in phases 6–7, `wr` in phase 7 only, `rd` never in phases 5–7.
  - JMP: `ld_pc` in phases 6–7.
- HLT (0):
  - Phase 4 shows `halt` = 1 and `inc_pc` = 1.
  - Then 20 cycles of `halt` = 1, phase = 4, all strobes 0, even with opcode changed to 2.
  - Reset recovers to phase 0.
- Stall (`VERIRISC_STALL_EN` only):
  - `stall` = 1 for 3 cycles in phase 7 with LDA: phase holds at 7, `rd` = 1, `ld_ac` = 0.
  - On release, `ld_ac` = 1 for exactly one cycle, then phase 0.
